// File: rtl/branch_resolve_queue.sv
// In-order branch tracker: records predictions, accepts out-of-order resolution,
// retires on ROB commit and drives predictor training / mispredict flush.
// Optional statistics counters are enabled by defining BRQ_STATS_EN.
module branch_resolve_queue #(
  parameter int unsigned BRQ_WIDTH = 3
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 iu_to_brq_valid,
  input  logic [31:0]          iu_to_brq_pc,
  input  logic                 iu_to_brq_pred,
  input  logic [31:0]          iu_to_brq_alt_pc,
  output logic                 brq_to_iu_full,
  output logic [BRQ_WIDTH-1:0] brq_to_iu_tag,
  input  logic                 alu_to_brq_valid,
  input  logic [BRQ_WIDTH-1:0] alu_to_brq_tag,
  input  logic                 alu_to_brq_actual_br,
  output logic                 brq_to_rob_head_resolved,
  input  logic                 rob_to_brq_commit,
  output logic                 brq_to_bp_ready,
  output logic [31:0]          brq_to_bp_pc,
  output logic                 brq_to_bp_actual_br,
  output logic                 brq_to_all_flush,
  output logic [31:0]          brq_to_iu_redirect_pc,
  output logic [31:0]          brq_stat_commits,
  output logic [31:0]          brq_stat_mispredicts
);

  localparam int unsigned DEPTH = 2 ** BRQ_WIDTH;

  logic [DEPTH-1:0]     valid_q, valid_d;
  logic [DEPTH-1:0]     resolved_q, resolved_d;
  logic [DEPTH-1:0]     pred_q, pred_d;
  logic [DEPTH-1:0]     actual_q, actual_d;
  logic [31:0]          pc_q [DEPTH];
  logic [31:0]          pc_d [DEPTH];
  logic [31:0]          alt_q [DEPTH];
  logic [31:0]          alt_d [DEPTH];
  logic [BRQ_WIDTH-1:0] head_q, head_d;
  logic [BRQ_WIDTH-1:0] tail_q, tail_d;
  logic [BRQ_WIDTH:0]   count_q, count_d;
  logic                 bp_ready_q, bp_ready_d;
  logic [31:0]          bp_pc_q, bp_pc_d;
  logic                 bp_actual_q, bp_actual_d;
  logic                 flush_q, flush_d;
  logic [31:0]          redirect_q, redirect_d;

  logic full, head_resolved, commit, mispred, push, resolve;

  assign full          = (count_q == (BRQ_WIDTH+1)'(DEPTH));
  assign head_resolved = valid_q[head_q] && resolved_q[head_q];
  assign commit        = rob_to_brq_commit && head_resolved;
  assign mispred       = actual_q[head_q] != pred_q[head_q];
  // A full queue still accepts a push when a correctly predicted head retires
  // in the same cycle; the new entry reuses the slot being vacated.
  assign push    = iu_to_brq_valid && !flush_q && (!full || (commit && !mispred));
  assign resolve = alu_to_brq_valid && valid_q[alu_to_brq_tag] && !flush_q;

  always_comb begin
    valid_d     = valid_q;
    resolved_d  = resolved_q;
    pred_d      = pred_q;
    actual_d    = actual_q;
    pc_d        = pc_q;
    alt_d       = alt_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    bp_ready_d  = bp_ready_q;
    bp_pc_d     = bp_pc_q;
    bp_actual_d = bp_actual_q;
    flush_d     = flush_q;
    redirect_d  = redirect_q;
    if (rdy_in) begin
      bp_ready_d = commit;
      flush_d    = commit && mispred;
      if (commit) begin
        bp_pc_d     = pc_q[head_q];
        bp_actual_d = actual_q[head_q];
      end
      if (commit && mispred) begin
        redirect_d = alt_q[head_q];
        valid_d    = '0;
        head_d     = '0;
        tail_d     = '0;
        count_d    = '0;
      end else begin
        if (resolve) begin
          resolved_d[alu_to_brq_tag] = 1'b1;
          actual_d[alu_to_brq_tag]   = alu_to_brq_actual_br;
        end
        if (commit) begin
          valid_d[head_q] = 1'b0;
          head_d          = head_q + 1'b1;
        end
        if (push) begin
          valid_d[tail_q]    = 1'b1;
          resolved_d[tail_q] = 1'b0;
          pred_d[tail_q]     = iu_to_brq_pred;
          pc_d[tail_q]       = iu_to_brq_pc;
          alt_d[tail_q]      = iu_to_brq_alt_pc;
          tail_d             = tail_q + 1'b1;
        end
        if (push && !commit)      count_d = count_q + 1'b1;
        else if (commit && !push) count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid_q     <= '0;
      resolved_q  <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      bp_ready_q  <= 1'b0;
      bp_pc_q     <= '0;
      bp_actual_q <= 1'b0;
      flush_q     <= 1'b0;
      redirect_q  <= '0;
    end else begin
      valid_q     <= valid_d;
      resolved_q  <= resolved_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      bp_ready_q  <= bp_ready_d;
      bp_pc_q     <= bp_pc_d;
      bp_actual_q <= bp_actual_d;
      flush_q     <= flush_d;
      redirect_q  <= redirect_d;
    end
  end

  // Payload fields are qualified by valid, so they need no reset.
  always_ff @(posedge clk_in) begin
    pred_q   <= pred_d;
    actual_q <= actual_d;
    pc_q     <= pc_d;
    alt_q    <= alt_d;
  end

`ifdef BRQ_STATS_EN
  logic [31:0] stat_commits_q, stat_mispredicts_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      stat_commits_q     <= '0;
      stat_mispredicts_q <= '0;
    end else if (rdy_in && commit) begin
      stat_commits_q <= stat_commits_q + 32'd1;
      if (mispred) stat_mispredicts_q <= stat_mispredicts_q + 32'd1;
    end
  end

  assign brq_stat_commits     = stat_commits_q;
  assign brq_stat_mispredicts = stat_mispredicts_q;
`else
  assign brq_stat_commits     = 32'h0;
  assign brq_stat_mispredicts = 32'h0;
`endif

  assign brq_to_iu_full           = full;
  assign brq_to_iu_tag            = tail_q;
  assign brq_to_rob_head_resolved = head_resolved;
  assign brq_to_bp_ready          = bp_ready_q && rdy_in;
  assign brq_to_all_flush         = flush_q && rdy_in;
  assign brq_to_bp_pc             = bp_pc_q;
  assign brq_to_bp_actual_br      = bp_actual_q;
  assign brq_to_iu_redirect_pc    = redirect_q;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed bench for branch_resolve_queue; expected values are hand-computed.
module tb_branch_resolve_queue;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in;
  logic        iu_to_brq_valid, iu_to_brq_pred;
  logic [31:0] iu_to_brq_pc, iu_to_brq_alt_pc;
  logic        brq_to_iu_full;
  logic [2:0]  brq_to_iu_tag;
  logic        alu_to_brq_valid, alu_to_brq_actual_br;
  logic [2:0]  alu_to_brq_tag;
  logic        brq_to_rob_head_resolved, rob_to_brq_commit;
  logic        brq_to_bp_ready, brq_to_bp_actual_br, brq_to_all_flush;
  logic [31:0] brq_to_bp_pc, brq_to_iu_redirect_pc;
  logic [31:0] brq_stat_commits, brq_stat_mispredicts;

  int vectors = 0;
  int miscompares = 0;

  branch_resolve_queue #(.BRQ_WIDTH(3)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .iu_to_brq_valid(iu_to_brq_valid), .iu_to_brq_pc(iu_to_brq_pc),
    .iu_to_brq_pred(iu_to_brq_pred), .iu_to_brq_alt_pc(iu_to_brq_alt_pc),
    .brq_to_iu_full(brq_to_iu_full), .brq_to_iu_tag(brq_to_iu_tag),
    .alu_to_brq_valid(alu_to_brq_valid), .alu_to_brq_tag(alu_to_brq_tag),
    .alu_to_brq_actual_br(alu_to_brq_actual_br),
    .brq_to_rob_head_resolved(brq_to_rob_head_resolved),
    .rob_to_brq_commit(rob_to_brq_commit),
    .brq_to_bp_ready(brq_to_bp_ready), .brq_to_bp_pc(brq_to_bp_pc),
    .brq_to_bp_actual_br(brq_to_bp_actual_br),
    .brq_to_all_flush(brq_to_all_flush),
    .brq_to_iu_redirect_pc(brq_to_iu_redirect_pc),
    .brq_stat_commits(brq_stat_commits),
    .brq_stat_mispredicts(brq_stat_mispredicts)
  );

  always #5 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_inputs();
    iu_to_brq_valid = 0; iu_to_brq_pc = '0; iu_to_brq_pred = 0; iu_to_brq_alt_pc = '0;
    alu_to_brq_valid = 0; alu_to_brq_tag = '0; alu_to_brq_actual_br = 0;
    rob_to_brq_commit = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rdy_in = 1; rst_in = 1;
    step();
    rst_in = 0;
  endtask

  task automatic push(input logic [31:0] pc, input logic pred, input logic [31:0] alt);
    iu_to_brq_valid = 1; iu_to_brq_pc = pc; iu_to_brq_pred = pred; iu_to_brq_alt_pc = alt;
    step();
    iu_to_brq_valid = 0;
  endtask

  task automatic resolve(input logic [2:0] tag, input logic act);
    alu_to_brq_valid = 1; alu_to_brq_tag = tag; alu_to_brq_actual_br = act;
    step();
    alu_to_brq_valid = 0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (brq_to_iu_full !== 1'b0 || brq_to_iu_tag !== 3'd0 || brq_to_rob_head_resolved !== 1'b0) begin
      $display("FAIL reset_ctrl: full=%b tag=%0d hr=%b want 0/0/0", brq_to_iu_full, brq_to_iu_tag, brq_to_rob_head_resolved);
      miscompares++;
    end
    vectors++;
    if (brq_to_bp_ready !== 1'b0 || brq_to_all_flush !== 1'b0 || brq_to_bp_pc !== 32'h0 ||
        brq_to_iu_redirect_pc !== 32'h0 || brq_to_bp_actual_br !== 1'b0) begin
      $display("FAIL reset_out: rdy=%b fl=%b pc=%h rpc=%h want all 0", brq_to_bp_ready, brq_to_all_flush, brq_to_bp_pc, brq_to_iu_redirect_pc);
      miscompares++;
    end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (brq_to_iu_tag !== 3'(i)) begin
        $display("FAIL fill_tag%0d: got %0d want %0d", i, brq_to_iu_tag, i);
        miscompares++;
      end
      push(32'h1000 + 32'(4*i), 1'b1, 32'h0);
    end
    vectors++;
    if (brq_to_iu_full !== 1'b1) begin
      $display("FAIL fill_full: got %b want 1", brq_to_iu_full);
      miscompares++;
    end
    push(32'h1020, 1'b1, 32'h0);
    vectors++;
    if (dut.count_q !== 4'd8 || brq_to_iu_tag !== 3'd0 || brq_to_iu_full !== 1'b1) begin
      $display("FAIL fill_drop: count=%0d tag=%0d full=%b want 8/0/1", dut.count_q, brq_to_iu_tag, brq_to_iu_full);
      miscompares++;
    end
  endtask

  task automatic test_out_of_order();
    do_reset();
    push(32'h2000, 1'b0, 32'h2010);
    push(32'h2004, 1'b0, 32'h2008);
    resolve(3'd1, 1'b0);
    vectors++;
    if (brq_to_rob_head_resolved !== 1'b0) begin
      $display("FAIL ooo_hr_b: got %b want 0", brq_to_rob_head_resolved);
      miscompares++;
    end
    alu_to_brq_valid = 1; alu_to_brq_tag = 3'd0; alu_to_brq_actual_br = 0;
    #1;
    vectors++;
    if (brq_to_rob_head_resolved !== 1'b0) begin
      $display("FAIL ooo_no_fwd: got %b want 0", brq_to_rob_head_resolved);
      miscompares++;
    end
    step();
    alu_to_brq_valid = 0;
    vectors++;
    if (brq_to_rob_head_resolved !== 1'b1) begin
      $display("FAIL ooo_hr_a: got %b want 1", brq_to_rob_head_resolved);
      miscompares++;
    end
    rob_to_brq_commit = 1;
    step();
    rob_to_brq_commit = 0;
    vectors++;
    if (brq_to_bp_ready !== 1'b1 || brq_to_bp_pc !== 32'h2000 || brq_to_bp_actual_br !== 1'b0 || brq_to_all_flush !== 1'b0) begin
      $display("FAIL ooo_train: rdy=%b pc=%h act=%b fl=%b want 1/00002000/0/0", brq_to_bp_ready, brq_to_bp_pc, brq_to_bp_actual_br, brq_to_all_flush);
      miscompares++;
    end
    step();
    vectors++;
    if (brq_to_bp_ready !== 1'b0 || dut.count_q !== 4'd1 || brq_to_rob_head_resolved !== 1'b1) begin
      $display("FAIL ooo_after: rdy=%b count=%0d hr=%b want 0/1/1", brq_to_bp_ready, dut.count_q, brq_to_rob_head_resolved);
      miscompares++;
    end
  endtask

  task automatic test_mispredict();
    do_reset();
    push(32'h3000, 1'b1, 32'h3004);
    resolve(3'd0, 1'b0);
    rob_to_brq_commit = 1;
    step();
    rob_to_brq_commit = 0;
    vectors++;
    if (brq_to_bp_ready !== 1'b1 || brq_to_all_flush !== 1'b1 || brq_to_iu_redirect_pc !== 32'h3004 ||
        brq_to_bp_pc !== 32'h3000 || brq_to_bp_actual_br !== 1'b0) begin
      $display("FAIL mp_pulse: rdy=%b fl=%b rpc=%h pc=%h act=%b want 1/1/00003004/00003000/0",
               brq_to_bp_ready, brq_to_all_flush, brq_to_iu_redirect_pc, brq_to_bp_pc, brq_to_bp_actual_br);
      miscompares++;
    end
    vectors++;
    if (dut.count_q !== 4'd0 || brq_to_iu_tag !== 3'd0) begin
      $display("FAIL mp_empty: count=%0d tag=%0d want 0/0", dut.count_q, brq_to_iu_tag);
      miscompares++;
    end
    rdy_in = 0;
    #1;
    vectors++;
    if (brq_to_all_flush !== 1'b0 || brq_to_bp_ready !== 1'b0 || brq_to_iu_redirect_pc !== 32'h3004) begin
      $display("FAIL mp_rdy_gate: fl=%b rdy=%b rpc=%h want 0/0/00003004", brq_to_all_flush, brq_to_bp_ready, brq_to_iu_redirect_pc);
      miscompares++;
    end
    rdy_in = 1;
    push(32'h4000, 1'b0, 32'h0);
    vectors++;
    if (dut.count_q !== 4'd0 || brq_to_iu_tag !== 3'd0 || brq_to_all_flush !== 1'b0 || brq_to_bp_ready !== 1'b0) begin
      $display("FAIL mp_drop: count=%0d tag=%0d fl=%b rdy=%b want 0/0/0/0", dut.count_q, brq_to_iu_tag, brq_to_all_flush, brq_to_bp_ready);
      miscompares++;
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 8; i++) push(32'h5000 + 32'(4*i), 1'b1, 32'h0);
    resolve(3'd0, 1'b1);
    vectors++;
    if (brq_to_rob_head_resolved !== 1'b1 || brq_to_iu_full !== 1'b1) begin
      $display("FAIL b2b_pre: hr=%b full=%b want 1/1", brq_to_rob_head_resolved, brq_to_iu_full);
      miscompares++;
    end
    rob_to_brq_commit = 1;
    push(32'h6000, 1'b1, 32'h0);
    rob_to_brq_commit = 0;
    vectors++;
    if (dut.count_q !== 4'd8 || brq_to_iu_full !== 1'b1 || brq_to_iu_tag !== 3'd1 || dut.pc_q[0] !== 32'h6000) begin
      $display("FAIL b2b_state: count=%0d full=%b tag=%0d pc0=%h want 8/1/1/00006000", dut.count_q, brq_to_iu_full, brq_to_iu_tag, dut.pc_q[0]);
      miscompares++;
    end
    vectors++;
    if (brq_to_bp_ready !== 1'b1 || brq_to_bp_pc !== 32'h5000 || brq_to_all_flush !== 1'b0) begin
      $display("FAIL b2b_train: rdy=%b pc=%h fl=%b want 1/00005000/0", brq_to_bp_ready, brq_to_bp_pc, brq_to_all_flush);
      miscompares++;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 5; i++) push(32'h7000 + 32'(4*i), 1'b1, 32'h0);
    resolve(3'd0, 1'b1);
    rob_to_brq_commit = 1; rst_in = 1;
    step();
    rob_to_brq_commit = 0; rst_in = 0;
    vectors++;
    if (dut.count_q !== 4'd0 || brq_to_bp_ready !== 1'b0 || brq_to_all_flush !== 1'b0 ||
        brq_to_iu_tag !== 3'd0 || brq_to_rob_head_resolved !== 1'b0) begin
      $display("FAIL rst_mid: count=%0d rdy=%b fl=%b tag=%0d hr=%b want 0/0/0/0/0",
               dut.count_q, brq_to_bp_ready, brq_to_all_flush, brq_to_iu_tag, brq_to_rob_head_resolved);
      miscompares++;
    end
  endtask

  task automatic test_freeze();
    do_reset();
    rdy_in = 0;
    push(32'h8000, 1'b0, 32'h0);
    vectors++;
    if (brq_to_iu_tag !== 3'd0 || dut.count_q !== 4'd0) begin
      $display("FAIL freeze: tag=%0d count=%0d want 0/0", brq_to_iu_tag, dut.count_q);
      miscompares++;
    end
    rdy_in = 1;
    push(32'h8000, 1'b0, 32'h0);
    vectors++;
    if (brq_to_iu_tag !== 3'd1 || dut.count_q !== 4'd1) begin
      $display("FAIL unfreeze: tag=%0d count=%0d want 1/1", brq_to_iu_tag, dut.count_q);
      miscompares++;
    end
  endtask

  task automatic test_stats();
    logic [31:0] exp_c, exp_m;
`ifdef BRQ_STATS_EN
    exp_c = 32'd3; exp_m = 32'd1;
`else
    exp_c = 32'd0; exp_m = 32'd0;
`endif
    do_reset();
    for (int i = 0; i < 3; i++) push(32'h9000 + 32'(4*i), 1'b1, 32'h9100);
    resolve(3'd0, 1'b1);
    resolve(3'd1, 1'b1);
    resolve(3'd2, 1'b0);
    rob_to_brq_commit = 1;
    step(); step(); step();
    rob_to_brq_commit = 0;
    vectors++;
    if (brq_to_all_flush !== 1'b1 || brq_to_bp_pc !== 32'h9008) begin
      $display("FAIL stats_flush: fl=%b pc=%h want 1/00009008", brq_to_all_flush, brq_to_bp_pc);
      miscompares++;
    end
    step();
    vectors++;
    if (brq_stat_commits !== exp_c || brq_stat_mispredicts !== exp_m) begin
      $display("FAIL stats: commits=%0d mispredicts=%0d want %0d/%0d", brq_stat_commits, brq_stat_mispredicts, exp_c, exp_m);
      miscompares++;
    end
  endtask

  initial begin
    rst_in = 1; rdy_in = 1;
    idle_inputs();
    test_reset();
    test_fill();
    test_out_of_order();
    test_mispredict();
    test_back_to_back();
    test_reset_mid();
    test_freeze();
    test_stats();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
